i2s_encoder: RTL and testbench
==============================

# i2s_encoder

I2S transmitter for the audio path: it takes stereo PCM sample pairs over a valid/ready handshake and drives SCLK, WS and serial data to an external I2S DAC or codec. It is the transmit counterpart of `i2s_decoder` and uses the same Philips framing: MSB first, one SCLK after each WS edge. It generates its own bit clock from the system clock, so one instance drives a complete I2S link.

## Interface
- `DATAWIDTH`, 24, sample width per channel; must be ≤ `SLOT_BITS`-1.
- `SLOT_BITS`, 32, SCLK periods per channel slot; a frame is 2*`SLOT_BITS` SCLKs.
- `SCLK_DIV`, 30, sys_clk cycles per SCLK period; even, ≥ 2. 60 MHz / 30 = 2 MHz.
- `sys_clk` input 1: the single clock; all logic is on its rising edge.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: run enable. 1 = transmit frames, 0 = link idle.
- `in_valid` input 1: the `in_l` / `in_r` pair is valid.
- `in_ready` output 1: the holding buffer is empty and can accept a pair.
- `in_l` input `DATAWIDTH`: left-channel sample, two's complement.
- `in_r` input `DATAWIDTH`: right-channel sample, two's complement.
- `i2s_sclk` output 1: bit clock.
- `i2s_ws` output 1: word select; 0 = left slot, 1 = right slot.
- `i2s_sdata` output 1: serial data.
- `underflow` output 1: one-cycle pulse when a frame starts with no sample buffered.

## Operation
- **States:** IDLE and RUN.
  - IDLE → RUN on the first cycle with `en`=1.
  - RUN → IDLE on the first cycle with `en`=0, i.e. an immediate stop, not at a frame boundary.
  - Reset puts the block in IDLE.
- **IDLE:**
  - `i2s_sclk`, `i2s_ws`, `i2s_sdata` held at 0.
  - Divider counter, bit position and shift registers cleared.
  - Holding buffer contents are kept.
- **Holding buffer:** one stereo pair plus a full flag; `in_ready` = !full.
  - A pair is accepted on any cycle with `in_valid` && `in_ready`, in either state.
  - The buffer is freed only by a frame load.
- **Bit position** `p` runs 0..2*`SLOT_BITS`-1 and wraps. Slot position is `q` = `p` mod `SLOT_BITS`.
  - `i2s_ws` = (`p` ≥ `SLOT_BITS`).
  - `i2s_sdata` = sample[`DATAWIDTH`-`q`] for `q` in 1..`DATAWIDTH`, otherwise 0. Left sample in the left slot, right sample in the right slot.
- **Frame load** happens on entry to `p`=0, either the IDLE→RUN cycle or a wrap:
  - Buffer full: copy the pair into the shift registers and clear full.
  - Buffer empty: load zeros and pulse `underflow`.
  - If an accept and a load with an empty buffer happen in the same cycle, the load sees empty (underflow, zeros sent). The accepted pair stays buffered for the next frame.
- **Arithmetic:** there is none. Samples are sent bit-exact; padding bits are 0.

## Timing
- **Divider:** counter `d` runs 0..`SCLK_DIV`/2-1.
  - When `d` reaches its terminal count, `i2s_sclk` toggles and `d` wraps to 0.
  - A falling event is terminal count with `i2s_sclk`=1.
- **Falling event:** `p` advances, and `i2s_ws` and `i2s_sdata` update in that same cycle. Data therefore changes on SCLK fall and is stable for the receiver's rising-edge sample.
- **IDLE→RUN cycle:** `p`=0, `i2s_ws`=0, `i2s_sdata`=0, `i2s_sclk` stays 0. The first SCLK rise occurs `SCLK_DIV`/2 cycles later.
- **Output registers:** all outputs are registered.
- **Reset values:**
  - `i2s_sclk`, `i2s_ws`, `i2s_sdata`, `underflow` = 0.
  - `in_ready` = 1.
- **Latency:** a pair accepted during frame N with the buffer empty puts its left MSB on `i2s_sdata` at `p`=1 of frame N+1. That is one SCLK (`SCLK_DIV` cycles) after the load.
- **Throughput:** one pair per frame, i.e. 2*`SLOT_BITS`*`SCLK_DIV` cycles (1920 at the defaults).

## Configuration
- `I2S_ENC_UNDERFLOW_CNT_EN` defined:
  - Adds output `underflow_cnt` [15:0], reset 0.
  - Increments on each `underflow` pulse and saturates at 16'hFFFF.
  - Cleared by reset only.
- Not defined: the port and counter are absent; the `underflow` pulse is unchanged.

## Structure
- Package `i2s_pkg`:
  - Default `DATAWIDTH`, `SLOT_BITS` and `SCLK_DIV` constants.
  - State enum type (IDLE, RUN).
  - This package is shared with `i2s_decoder`.
- Sub-module `i2s_sclk_gen`:
  - Contains the divider, `i2s_sclk` register and falling-event strobe, with `en` as a synchronous clear.
  - The top level holds the buffer, the bit-position counter, the shift registers and the state.

## Test plan
- **Basic frame:** reset, `en`=1, push L=24'hA5C3F0, R=24'h0F0F01 before the first wrap.
  - Frame 2: WS low for 32 SCLKs, bits 1..24 = A5C3F0 MSB first.
  - Then WS high with 0F0F01; all padding bits 0.
- **Underflow:** `en`=1 with no push.
  - `underflow` pulses on the IDLE→RUN cycle and on every wrap.
  - `i2s_sdata` stays 0 throughout.
  - With the macro, `underflow_cnt` = 3 after 2 full frames.
- **Back-pressure:** hold `in_valid`=1 with incrementing data.
  - `in_ready` deasserts after one accept and reasserts on the cycle after each frame load.
  - Exactly one pair is sent per 1920 cycles, with no pair lost or repeated.
- **Simultaneous accept and load:** assert `in_valid` on the exact wrap cycle with the buffer empty.
  - `underflow` pulses and that frame sends zeros.
  - The pair is sent in the following frame.
- **Mid-frame stop:** drop `en` at `p`=40.
  - The next cycle has SCLK, WS and SDATA at 0.
  - On re-enable, framing restarts at `p`=0 and the buffered pair is sent intact.
- **Async reset mid-RUN:** assert `sys_rst_n`=0 with no clock edge.
  - All outputs reach their reset values immediately and `in_ready`=1.

Source files
------------

// File: rtl/i2s_encoder_pkg.sv
// Shared I2S definitions: default link geometry and the transmit/receive state type.
package i2s_pkg;
    localparam int I2S_DATAWIDTH = 24;
    localparam int I2S_SLOT_BITS = 32;
    localparam int I2S_SCLK_DIV  = 30;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_e;
endpackage

// File: rtl/i2s_encoder_if.sv
// Stereo sample handshake into the I2S encoder (valid/ready, one L/R pair per beat).
interface i2s_encoder_if
    import i2s_pkg::*;
#(
    parameter int DATAWIDTH = I2S_DATAWIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_l;
    logic [DATAWIDTH-1:0] in_r;

    modport master (output in_valid, output in_l, output in_r, input in_ready);
    modport slave  (input in_valid, input in_l, input in_r, output in_ready);
endinterface

// File: rtl/i2s_encoder_sclk_gen.sv
// Bit-clock divider: toggles sclk every SCLK_DIV/2 cycles and flags the falling edge.
module i2s_sclk_gen #(
    parameter int SCLK_DIV = 30
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en_i,
    output logic sclk_o,
    output logic fall_o
);
    localparam int HALF = SCLK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] TC = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;
    logic          sclk_q;
    logic          tc;

    assign tc     = (cnt_q == TC);
    // Strobe is combinational so the top updates data on the same edge sclk drops.
    assign fall_o = en_i && tc && sclk_q;
    assign sclk_o = sclk_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (tc) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/i2s_encoder.sv
// I2S (Philips) transmitter: buffers one stereo pair and serialises it MSB first.
// Optional I2S_ENC_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module i2s_encoder
    import i2s_pkg::*;
#(
    parameter int DATAWIDTH = I2S_DATAWIDTH,
    parameter int SLOT_BITS = I2S_SLOT_BITS,
    parameter int SCLK_DIV  = I2S_SCLK_DIV
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          en,
    i2s_encoder_if.slave  in_if,
    output logic          i2s_sclk,
    output logic          i2s_ws,
    output logic          i2s_sdata,
    output logic          underflow
`ifdef I2S_ENC_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]   underflow_cnt
`endif
);
    localparam int PW = $clog2(2 * SLOT_BITS);
    localparam logic [PW-1:0] P_LAST = PW'(2 * SLOT_BITS - 1);
    localparam logic [PW-1:0] S_P    = PW'(SLOT_BITS);
    localparam logic [PW-1:0] D_P    = PW'(DATAWIDTH);

    i2s_state_e           state_q;
    logic [PW-1:0]        p_q, p_d, q_d;
    logic                 ws_q, ws_d, sd_q, bit_d;
    logic                 uf_q, full_q;
    logic [DATAWIDTH-1:0] buf_l_q, buf_r_q, sh_l_q, sh_r_q;
    logic                 run, tick_en, sclk, fall, load, accept;

    assign run     = (state_q == ST_RUN);
    assign tick_en = run && en;

    i2s_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en_i      (tick_en),
        .sclk_o    (sclk),
        .fall_o    (fall)
    );

    assign p_d    = (p_q == P_LAST) ? '0 : p_q + 1'b1;
    assign ws_d   = (p_d >= S_P);
    assign q_d    = ws_d ? p_d - S_P : p_d;
    assign bit_d  = (q_d != '0) && (q_d <= D_P);
    // A frame starts either on the enable cycle or when p wraps back to 0.
    assign load   = en && (!run || (fall && p_q == P_LAST));
    assign accept = in_if.in_valid && !full_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            ws_q    <= 1'b0;
            sd_q    <= 1'b0;
            uf_q    <= 1'b0;
            full_q  <= 1'b0;
            buf_l_q <= '0;
            buf_r_q <= '0;
            sh_l_q  <= '0;
            sh_r_q  <= '0;
        end else begin
            uf_q <= 1'b0;
            // An accept can only coincide with a load when the buffer was empty,
            // so the new pair survives for the following frame.
            if (accept) begin
                buf_l_q <= in_if.in_l;
                buf_r_q <= in_if.in_r;
                full_q  <= 1'b1;
            end else if (load) begin
                full_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: if (en) state_q <= ST_RUN;
                ST_RUN: begin
                    if (!en) begin
                        state_q <= ST_IDLE;
                        p_q     <= '0;
                        ws_q    <= 1'b0;
                        sd_q    <= 1'b0;
                        sh_l_q  <= '0;
                        sh_r_q  <= '0;
                    end else if (fall) begin
                        p_q  <= p_d;
                        ws_q <= ws_d;
                        sd_q <= 1'b0;
                        if (bit_d) begin
                            if (ws_d) begin
                                sd_q   <= sh_r_q[DATAWIDTH-1];
                                sh_r_q <= sh_r_q << 1;
                            end else begin
                                sd_q   <= sh_l_q[DATAWIDTH-1];
                                sh_l_q <= sh_l_q << 1;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (load) begin
                sh_l_q <= full_q ? buf_l_q : '0;
                sh_r_q <= full_q ? buf_r_q : '0;
                uf_q   <= !full_q;
            end
        end
    end

    assign in_if.in_ready = !full_q;
    assign i2s_sclk       = sclk;
    assign i2s_ws         = ws_q;
    assign i2s_sdata      = sd_q;
    assign underflow      = uf_q;

`ifdef I2S_ENC_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ucnt_q <= '0;
        end else if (load && !full_q && ucnt_q != 16'hFFFF) begin
            ucnt_q <= ucnt_q + 1'b1;
        end
    end

    assign underflow_cnt = ucnt_q;
`endif
endmodule

// File: tb/tb_i2s_encoder.sv
// Scoreboard bench for i2s_encoder: a frame-level model predicts each frame's pair,
// a monitor deserialises the link on SCLK rises and compares.
module tb_i2s_encoder;
    import i2s_pkg::*;

    localparam int DW    = 24;
    localparam int SB    = 32;
    localparam int DIV   = 30;
    localparam int H     = DIV / 2;
    localparam int NB    = 2 * SB;
    localparam int FRAME = NB * DIV;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic en = 1'b0;
    logic i2s_sclk, i2s_ws, i2s_sdata, underflow;
`ifdef I2S_ENC_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    i2s_encoder_if #(.DATAWIDTH(DW)) bus ();

    i2s_encoder #(.DATAWIDTH(DW), .SLOT_BITS(SB), .SCLK_DIV(DIV)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .in_if     (bus),
        .i2s_sclk  (i2s_sclk),
        .i2s_ws    (i2s_ws),
        .i2s_sdata (i2s_sdata),
        .underflow (underflow)
`ifdef I2S_ENC_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames start on enable and every FRAME cycles after it;
    // each start consumes the buffered pair (or zeros, flagging underflow).
    pair_t expq[$];
    pair_t m_buf;
    logic  m_run = 1'b0;
    logic  m_full = 1'b0;
    logic  exp_uf = 1'b0;
    int    m_cnt = 0;
    int    abort_cnt = 0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_run  = 1'b0;
            m_full = 1'b0;
            exp_uf = 1'b0;
            expq.delete();
        end else begin
            logic  acc, ld;
            pair_t z;
            acc    = bus.in_valid && !m_full;
            ld     = 1'b0;
            exp_uf = 1'b0;
            if (!m_run) begin
                if (en) begin m_run = 1'b1; m_cnt = 0; ld = 1'b1; end
            end else if (!en) begin
                m_run = 1'b0;
                abort_cnt++;
            end else begin
                m_cnt++;
                if (m_cnt == FRAME) begin m_cnt = 0; ld = 1'b1; end
            end
            if (ld) begin
                if (m_full) expq.push_back(m_buf);
                else begin
                    z.l = '0; z.r = '0;
                    expq.push_back(z);
                    exp_uf = 1'b1;
                end
                m_full = 1'b0;
            end
            if (acc) begin
                m_buf.l = bus.in_l;
                m_buf.r = bus.in_r;
                m_full  = 1'b1;
            end
        end
    end

    // Monitor: capture WS/SDATA at every SCLK rise, compare whole frames.
    int            nbits = 0;
    int            abort_seen = 0;
    logic          sclk_prev = 1'b0;
    logic [NB-1:0] ws_cap, sd_cap;

    task automatic check_frame();
        pair_t         e;
        logic [NB-1:0] ews, esd;
        logic [DW-1:0] s;
        int            q;
        if (expq.size() == 0) begin
            chk("frame_unexpected", 64'(1), 64'(0));
            return;
        end
        e = expq.pop_front();
        for (int i = 0; i < NB; i++) begin
            q      = i % SB;
            s      = (i >= SB) ? e.r : e.l;
            ews[i] = (i >= SB);
            esd[i] = (q >= 1 && q <= DW) ? s[DW-q] : 1'b0;
        end
        chk("frame_ws", 64'(ws_cap), 64'(ews));
        chk("frame_data", 64'(sd_cap), 64'(esd));
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            nbits = 0;
        end else begin
            if (abort_seen != abort_cnt) begin
                abort_seen = abort_cnt;
                nbits = 0;
                if (expq.size() != 0) void'(expq.pop_front());
            end
            chk("in_ready", 64'(bus.in_ready), 64'(!m_full));
            chk("underflow", 64'(underflow), 64'(exp_uf));
            if (!m_run) begin
                chk("idle_sclk", 64'(i2s_sclk), 64'(0));
                chk("idle_ws", 64'(i2s_ws), 64'(0));
                chk("idle_sdata", 64'(i2s_sdata), 64'(0));
            end else begin
                chk("sclk_phase", 64'(i2s_sclk), 64'(((m_cnt / H) % 2) == 1));
                if (i2s_sclk && !sclk_prev) begin
                    ws_cap[nbits] = i2s_ws;
                    sd_cap[nbits] = i2s_sdata;
                    nbits++;
                    if (nbits == NB) begin
                        nbits = 0;
                        check_frame();
                    end
                end
            end
        end
        sclk_prev = i2s_sclk;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_l = l;
        bus.in_r = r;
        while (bus.in_ready !== 1'b1 && t < 2 * FRAME) begin
            @(negedge sys_clk);
            t++;
        end
        @(negedge sys_clk);
        bus.in_valid = 1'b0;
        chk("push_timeout", 64'(t < 2 * FRAME), 64'(1));
    endtask

    task automatic wait_cnt(input int target);
        int t = 0;
        while (!(m_run && m_cnt == target) && t < 2 * FRAME) begin
            @(negedge sys_clk);
            t++;
        end
        chk("wait_timeout", 64'(t < 2 * FRAME), 64'(1));
    endtask

    task automatic async_reset();
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_sclk", 64'(i2s_sclk), 64'(0));
        chk("rst_ws", 64'(i2s_ws), 64'(0));
        chk("rst_sdata", 64'(i2s_sdata), 64'(0));
        chk("rst_underflow", 64'(underflow), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        en = 1'b0;
        bus.in_valid = 1'b0;
        cyc(2);
        sys_rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        int   k;
        logic acc_now;
        bus.in_valid = 1'b0;
        bus.in_l = '0;
        bus.in_r = '0;
        cyc(3);
        chk("reset_in_ready", 64'(bus.in_ready), 64'(1));
        chk("reset_sclk", 64'(i2s_sclk), 64'(0));
        chk("reset_ws", 64'(i2s_ws), 64'(0));
        chk("reset_sdata", 64'(i2s_sdata), 64'(0));
        chk("reset_underflow", 64'(underflow), 64'(0));
`ifdef I2S_ENC_UNDERFLOW_CNT_EN
        chk("reset_ucnt", 64'(underflow_cnt), 64'(0));
`endif
        sys_rst_n = 1'b1;
        cyc(2);

        // Basic frame: zeros, then the pushed pair, then zeros again.
        en = 1'b1;
        cyc(5);
        push(24'hA5C3F0, 24'h0F0F01);
        cyc(3 * FRAME);

        // Async reset in the middle of a running link.
        async_reset();

        // Pure underflow run.
        en = 1'b1;
        cyc(2 * FRAME + 3);
`ifdef I2S_ENC_UNDERFLOW_CNT_EN
        chk("ucnt_two_frames", 64'(underflow_cnt), 64'(3));
`endif

        // Back-pressure: valid held high, data bumped after each accept.
        k = 1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5 * FRAME; c++) begin
            bus.in_l = 24'(k);
            bus.in_r = ~24'(k);
            acc_now = bus.in_ready;
            @(negedge sys_clk);
            if (acc_now) k++;
        end
        bus.in_valid = 1'b0;
        chk("bp_accepts", 64'((k - 1) >= 5 && (k - 1) <= 6), 64'(1));
        cyc(2 * FRAME);

        // Accept on the exact load edge with an empty buffer.
        wait_cnt(FRAME - 1);
        chk("sim_empty_before", 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.in_l = 24'h123456;
        bus.in_r = 24'h654321;
        @(negedge sys_clk);
        bus.in_valid = 1'b0;
        chk("sim_underflow", 64'(underflow), 64'(1));
        chk("sim_held", 64'(bus.in_ready), 64'(0));
        cyc(2 * FRAME);

        // Mid-frame stop at p=40 with a pair waiting in the buffer.
        wait_cnt(5);
        push(24'h800001, 24'h7FFFFE);
        wait_cnt(40 * DIV);
        en = 1'b0;
        cyc(1);
        chk("stop_sclk", 64'(i2s_sclk), 64'(0));
        chk("stop_ws", 64'(i2s_ws), 64'(0));
        chk("stop_sdata", 64'(i2s_sdata), 64'(0));
        chk("stop_kept", 64'(bus.in_ready), 64'(0));
        cyc(20);
        en = 1'b1;
        cyc(2 * FRAME + 20);

        // Random pushes at random times.
        for (int n = 0; n < 6; n++) begin
            cyc($urandom_range(1, 2500));
            push(24'($urandom), 24'($urandom));
        end
        cyc(2 * FRAME);

        async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
